// File: rtl/writeback_stage_if.sv
// Writeback-stage bus: memory-stage pipeline registers, data-memory read
// response and register-file write port, grouped for the writeback stage.
interface writeback_stage_if;
    logic        stall_i;
    logic        valid_i;
    logic [63:0] rd_data_i;
    logic [4:0]  rd_idx_i;
    logic        rd_wr_en_i;
    logic [2:0]  rd_wr_src_1h_i;
    logic        mem_rd_i;
    logic [3:0]  mem_width_1h_i;
    logic        mem_sign_i;
    logic [2:0]  byte_addr_i;
    logic [63:0] dmem_rdata_i;
    logic        dmem_rvalid_i;

    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_idx_o;
    logic [63:0] rf_wr_data_o;
    logic        load_stall_ao;
    logic        retire_o;
    logic [63:0] instret_o;

    modport master (
        output stall_i, valid_i, rd_data_i, rd_idx_i, rd_wr_en_i, rd_wr_src_1h_i,
               mem_rd_i, mem_width_1h_i, mem_sign_i, byte_addr_i,
               dmem_rdata_i, dmem_rvalid_i,
        input  rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o, load_stall_ao,
               retire_o, instret_o
    );

    modport slave (
        input  stall_i, valid_i, rd_data_i, rd_idx_i, rd_wr_en_i, rd_wr_src_1h_i,
               mem_rd_i, mem_width_1h_i, mem_sign_i, byte_addr_i,
               dmem_rdata_i, dmem_rvalid_i,
        output rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o, load_stall_ao,
               retire_o, instret_o
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: aligns/extends load data, holds load responses that
// arrive during a stall, drives the register-file write port, counts retires.
module writeback_stage #(
    parameter bit INSTRET_EN = 1'b1
) (
    input logic              clk_i,
    input logic              rst_ni,
    writeback_stage_if.slave wb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HELD = 2'd2
    } state_t;

    state_t      state_q;
    logic [63:0] hold_q;
    logic [63:0] instret_q;

    logic        load;
    logic        data_avail;
    logic [63:0] load_data_raw;
    logic [63:0] shifted;
    logic [63:0] aligned;
    logic        load_stall;
    logic        retire;

    assign load          = wb.valid_i & wb.mem_rd_i;
    assign data_avail    = (state_q == HELD) | wb.dmem_rvalid_i;
    assign load_data_raw = (state_q == HELD) ? hold_q : wb.dmem_rdata_i;

    // Gated by rst_ni so nothing retires or stalls while reset is asserted.
    assign load_stall = rst_ni & load & ~data_avail;
    assign retire     = rst_ni & wb.valid_i & ~wb.stall_i & ~load_stall;

    assign shifted = load_data_raw >> {wb.byte_addr_i, 3'b000};

    always_comb begin
        aligned = '0;
        case (wb.mem_width_1h_i)
            4'b0001: aligned = {{56{wb.mem_sign_i & shifted[7]}},  shifted[7:0]};
            4'b0010: aligned = {{48{wb.mem_sign_i & shifted[15]}}, shifted[15:0]};
            4'b0100: aligned = {{32{wb.mem_sign_i & shifted[31]}}, shifted[31:0]};
            4'b1000: aligned = shifted;
            default: aligned = '0;
        endcase
    end

    assign wb.rf_wr_data_o  = (wb.rd_wr_src_1h_i == 3'b010) ? aligned : wb.rd_data_i;
    assign wb.rf_wr_idx_o   = wb.rd_idx_i;
    assign wb.rf_wr_en_o    = retire & wb.rd_wr_en_i & (wb.rd_idx_i != 5'd0);
    assign wb.load_stall_ao = load_stall;
    assign wb.retire_o      = retire;
    assign wb.instret_o     = instret_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        if (!wb.dmem_rvalid_i) begin
                            state_q <= WAIT;
                        end else if (wb.stall_i) begin
                            state_q <= HELD;
                            hold_q  <= wb.dmem_rdata_i;
                        end
                    end
                end
                WAIT: begin
                    if (wb.dmem_rvalid_i) begin
                        if (wb.stall_i) begin
                            state_q <= HELD;
                            hold_q  <= wb.dmem_rdata_i;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                // A second rvalid while holding is a protocol violation and is dropped.
                HELD: begin
                    if (!wb.stall_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            instret_q <= '0;
        end else if (INSTRET_EN && retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage, directly downstream of the memory stage. Consumes the memory-stage pipeline registers and the data-memory read response. Aligns and sign/zero-extends load data, selects the register-file write value, and drives the register-file write port. Holds load data that returns while the pipeline is stalled, raises a load stall while a load response is outstanding, and counts retired instructions.

Parameters:
INSTRET_EN, 1, 1 enables the retired-instruction counter; 0 ties instret_o to 0.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock, synchronous, active-low
stall_i  in  1  global pipeline stall; may include load_stall_ao
valid_i  in  1  instruction in WB is valid
rd_data_i  in  64  non-load result from memory stage
rd_idx_i  in  5  destination register index
rd_wr_en_i  in  1  instruction writes rd
rd_wr_src_1h_i  in  3  bit1 = load data; bit0/bit2 = rd_data_i
mem_rd_i  in  1  instruction is a load
mem_width_1h_i  in  4  bit0 byte, bit1 half, bit2 word, bit3 double
mem_sign_i  in  1  1 = sign-extend load
byte_addr_i  in  3  load address bits [2:0]
dmem_rdata_i  in  64  data-memory read data
dmem_rvalid_i  in  1  read data valid
rf_wr_en_o  out  1  register-file write enable
rf_wr_idx_o  out  5  register-file write index
rf_wr_data_o  out  64  register-file write data
load_stall_ao  out  1  combinational; load in WB without data yet
retire_o  out  1  combinational; instruction retires this cycle
instret_o  out  64  retired-instruction count

Behaviour:
- FSM states:
  - IDLE: no load data captured.
  - WAIT: valid load present, rvalid not yet seen.
  - HELD: load data captured in hold_q while stalled.
- Definitions:
  - load = valid_i & mem_rd_i.
  - data_avail = (state==HELD) | dmem_rvalid_i.
  - load_data_raw = HELD ? hold_q : dmem_rdata_i.
- load_stall_ao = load & ~data_avail. It does not depend on stall_i, so there is no combinational loop.
- retire_o = valid_i & ~stall_i & ~load_stall_ao.
- IDLE transitions:
  - load & ~rvalid -> WAIT.
  - load & rvalid & stall_i -> HELD, hold_q <= dmem_rdata_i.
  - Otherwise stay IDLE.
- WAIT transitions:
  - rvalid & ~stall_i -> IDLE (retires).
  - rvalid & stall_i -> HELD, capture.
  - Otherwise stay WAIT.
- HELD transitions:
  - ~stall_i -> IDLE (retires with hold_q).
  - rvalid in HELD is a protocol violation; ignore it and leave hold_q unchanged.
- Alignment: shifted = load_data_raw >> (byte_addr_i*8).
  - byte: [7:0]; half: [15:0]; word: [31:0]; double: all 64 bits.
  - Extend to 64 bits by sign if mem_sign_i, else by zero. Double ignores mem_sign_i.
  - Non-one-hot width: aligned load = 0.
- Write-value mux:
  - rd_wr_src_1h_i == 3'b010 -> aligned load.
  - 3'b001 or 3'b100 -> rd_data_i.
  - Any other value -> rd_data_i.
- rf_wr_en_o = retire_o & rd_wr_en_i & (rd_idx_i != 0).
- rf_wr_idx_o = rd_idx_i; rf_wr_data_o = mux output. Both are combinational.
- A load to x0 still waits for rvalid and still retires, with no write.
- instret_o: 64-bit counter, +1 on each retire_o cycle, wraps 2^64-1 -> 0.
- Reset (rst_ni low at posedge):
  - state = IDLE, hold_q = 0, instret_o = 0.
  - While rst_ni is low, rf_wr_en_o, retire_o and load_stall_ao are forced 0.
  - Reset in WAIT/HELD discards the pending load, and any later rvalid while IDLE with no load is ignored.
- Non-load in WB with rvalid high: rvalid is ignored.
- Latency: a load retires in the same cycle rvalid arrives if unstalled; otherwise on the first unstalled cycle.

Test Plan:
1. ALU op: valid_i=1, mem_rd_i=0, src=001, rd_idx=5, rd_data=0x1234, stall_i=0 -> rf_wr_en_o=1, idx 5, data 0x1234, instret 0->1.
2. LB signed: byte_addr=3, rdata=0x00000000_80000000 with byte3=0x80, rvalid same cycle -> rf_wr_data_o=0xFFFF_FFFF_FFFF_FF80. Same with mem_sign=0 -> 0x80.
3. Load, rvalid 2 cycles late: load_stall_ao=1 for 2 cycles, state WAIT, no write. On the rvalid cycle, LW at byte_addr=4 with rdata=0xDEADBEEF_00000000, unsigned -> data 0x00000000_DEADBEEF, write, back to IDLE.
4. rvalid while stall_i=1: rdata=0xAA..AA captured, HELD. rdata changes to 0. Stall released 3 cycles later -> LD writes 0xAAAA_AAAA_AAAA_AAAA, load_stall_ao=0 throughout HELD.
5. Write to x0 and instret wrap: rd_idx=0 -> rf_wr_en_o=0, retire_o=1. With instret preset to 2^64-1 via a long run/force, one retire -> 0.
6. Reset mid-WAIT: rst_ni low 1 cycle, then a stray rvalid with valid_i=0 -> no write, state IDLE, instret 0.
